// File: rtl/difftest_int_wb_queue.sv
// Multi-port integer writeback capture queue for difftest: up to NUM_PORTS
// writebacks enter per cycle in port order, one entry leaves per cycle (FWFT).

module difftest_int_wb_lane #(
  parameter int ADDR_W    = 8,
  parameter int FILTER_X0 = 1
) (
  input  logic              enable,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  output logic              eligible
);
  // x0 writes carry no architectural state, so they never reach the queue
  assign eligible = enable & valid & ~((FILTER_X0 != 0) && (address == '0));
endmodule

module difftest_int_wb_queue #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 16,
  parameter int FILTER_X0 = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] in_address,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [7:0]                  io_coreid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_address,
  output logic [DATA_W-1:0]           out_data,
  output logic [7:0]                  out_coreid,
  output logic [$clog2(DEPTH):0]      level,
  output logic [15:0]                 drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] take;
  logic [PTR_W-1:0]     widx [NUM_PORTS];
  logic [LVL_W-1:0]     free, cnt, push_n, drop_n;
  logic [16:0]          drop_sum;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic                 pop;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [7:0]        mem_core [DEPTH];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    difftest_int_wb_lane #(.ADDR_W(ADDR_W), .FILTER_X0(FILTER_X0)) u_lane (
      .enable   (enable),
      .valid    (in_valid[p]),
      .address  (in_address[p*ADDR_W +: ADDR_W]),
      .eligible (eligible[p])
    );
  end

  // Eligible ports are packed contiguously; a port's slot offset is the
  // number of eligible ports below it. Space freed by a pop is not reused
  // until the next cycle.
  always_comb begin
    free = LVL_W'(DEPTH) - level;
    cnt  = '0;
    take = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      widx[p] = wr_ptr + cnt[PTR_W-1:0];
      if (eligible[p]) begin
        take[p] = (cnt < free);
        cnt     = cnt + LVL_W'(1);
      end
    end
    push_n   = (cnt > free) ? free : cnt;
    drop_n   = cnt - push_n;
    drop_sum = {1'b0, drop_count} + 17'(drop_n);
    pop      = out_valid & out_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      drop_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + push_n[PTR_W-1:0];
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      level      <= level + push_n - LVL_W'(pop);
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Storage is deliberately unreset; outputs are masked while empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (take[p]) begin
          mem_addr[widx[p]] <= in_address[p*ADDR_W +: ADDR_W];
          mem_data[widx[p]] <= in_data[p*DATA_W +: DATA_W];
          mem_core[widx[p]] <= io_coreid;
        end
      end
    end
  end

  assign out_valid   = (level != '0);
  assign out_address = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
  assign out_coreid  = out_valid ? mem_core[rd_ptr] : '0;
endmodule

// File: tb/tb_difftest_int_wb_queue.sv
// Bench for difftest_int_wb_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.

module tb_difftest_int_wb_queue;
  localparam int NP = 4, AW = 8, DW = 64, D = 16, LW = 5;

  logic             clock = 1'b0;
  logic             reset, enable, out_ready;
  logic [NP-1:0]    in_valid;
  logic [NP*AW-1:0] in_address;
  logic [NP*DW-1:0] in_data;
  logic [7:0]       io_coreid;
  logic             out_valid;
  logic [AW-1:0]    out_address;
  logic [DW-1:0]    out_data;
  logic [7:0]       out_coreid;
  logic [LW-1:0]    level;
  logic [15:0]      drop_count;

  difftest_int_wb_queue #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .FILTER_X0(1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_address(in_address), .in_data(in_data), .io_coreid(io_coreid),
    .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
    .out_data(out_data), .out_coreid(out_coreid), .level(level),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  a;
    logic [63:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t mq[$];
  int   mdrop = 0;
  int   n_cmp = 0, n_err = 0;

  wire [101:0] obs = {out_valid, level, drop_count, out_address, out_data, out_coreid};

  function automatic logic [101:0] exp_state();
    ent_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    return {(mq.size() != 0), LW'(mq.size()), 16'(mdrop), h};
  endfunction

  task automatic idle(input logic rdy);
    enable = 1'b1; in_valid = '0; in_address = '0; in_data = '0;
    io_coreid = '0; out_ready = rdy;
  endtask

  task automatic set_port(input int p, input logic [7:0] a, input logic [63:0] d);
    in_valid[p] = 1'b1;
    in_address[p*AW +: AW] = a;
    in_data[p*DW +: DW] = d;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees.
  task automatic tick();
    ent_t acc[$];
    ent_t e;
    int   free;
    bit   pop;
    free = D - mq.size();
    pop  = (mq.size() != 0) && out_ready;
    for (int p = 0; p < NP; p++) begin
      if (enable && in_valid[p] && in_address[p*AW +: AW] != 0) begin
        if (acc.size() < free) begin
          e.a = in_address[p*AW +: AW];
          e.d = in_data[p*DW +: DW];
          e.c = io_coreid;
          acc.push_back(e);
        end else mdrop++;
      end
    end
    if (mdrop > 65535) mdrop = 65535;
    if (pop) void'(mq.pop_front());
    foreach (acc[i]) mq.push_back(acc[i]);
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; mq.delete(); mdrop = 0;
    #3; reset = 1'b0;
  endtask

  task automatic drain();
    idle(1'b1);
    for (int i = 0; i < 40 && mq.size() != 0; i++) tick();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_hold: got %h want 0", obs); end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_release: got %h want 0", obs); end
  endtask

  task automatic test_single();
    idle(1'b1); set_port(0, 8'd5, 64'h1234); io_coreid = 8'd0;
    tick();
    n_cmp++;
    if ({out_valid, out_address, out_data, out_coreid, level} !== {1'b1, 8'd5, 64'h1234, 8'd0, 5'd1}) begin
      n_err++; $display("FAIL single_head: got v=%b a=%h d=%h c=%h l=%0d want 1 05 1234 00 1",
                        out_valid, out_address, out_data, out_coreid, level);
    end
    idle(1'b1); tick();
    n_cmp++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_pop: got level=%0d valid=%b want 0 0", level, out_valid);
    end
  endtask

  task automatic test_multi_order();
    idle(1'b0); io_coreid = 8'h3C;
    for (int p = 0; p < NP; p++) set_port(p, 8'(p + 1), {$urandom, $urandom});
    tick();
    n_cmp++;
    if (level !== 5'd4) begin n_err++; $display("FAIL multi_level: got %0d want 4", level); end
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_address !== 8'(i + 1) || obs !== exp_state()) begin
        n_err++; $display("FAIL multi_order[%0d]: got addr=%0d state=%h want addr=%0d state=%h",
                          i, out_address, obs, i + 1, exp_state());
      end
      tick();
    end
  endtask

  task automatic test_x0_filter();
    int d0;
    drain();
    d0 = mdrop;
    idle(1'b0);
    set_port(1, 8'd0, 64'hDEAD); set_port(2, 8'd7, 64'hBEEF);
    tick();
    n_cmp++;
    if (level !== 5'd1 || out_address !== 8'd7 || out_data !== 64'hBEEF || drop_count !== 16'(d0)) begin
      n_err++; $display("FAIL x0_filter: got l=%0d a=%0d d=%h drop=%0d want 1 7 beef %0d",
                        level, out_address, out_data, drop_count, d0);
    end
  endtask

  task automatic test_overflow();
    int d0;
    drain();
    idle(1'b0);
    for (int c = 0; c < 4; c++) begin
      idle(1'b0);
      for (int p = 0; p < ((c == 3) ? 2 : 4); p++) set_port(p, 8'($urandom_range(1, 255)), {$urandom, $urandom});
      tick();
    end
    n_cmp++;
    if (level !== 5'd14) begin n_err++; $display("FAIL ovf_fill: got %0d want 14", level); end
    d0 = mdrop;
    idle(1'b1);
    for (int p = 0; p < NP; p++) set_port(p, 8'(p + 10), 64'(p + 100));
    tick();
    n_cmp++;
    if (level !== 5'd15 || drop_count !== 16'(d0 + 2)) begin
      n_err++; $display("FAIL ovf_drop: got l=%0d drop=%0d want 15 %0d", level, drop_count, d0 + 2);
    end
    n_cmp++;
    if (obs !== exp_state()) begin n_err++; $display("FAIL ovf_state: got %h want %h", obs, exp_state()); end
  endtask

  task automatic test_wrap();
    logic [63:0] got[$];
    pulse_reset();
    for (int i = 0; i < 60; i++) begin
      idle(1'b1);
      if (i < 40) set_port(0, 8'(i + 1), 64'(i));
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      n_cmp++;
      if (obs !== exp_state()) begin n_err++; $display("FAIL wrap_cycle[%0d]: got %h want %h", i, obs, exp_state()); end
    end
    n_cmp++;
    if (got.size() != 40 || drop_count !== 16'd0) begin
      n_err++; $display("FAIL wrap_count: got %0d drop=%0d want 40 0", got.size(), drop_count);
    end
    foreach (got[k]) begin
      n_cmp++;
      if (got[k] !== 64'(k)) begin n_err++; $display("FAIL wrap_order[%0d]: got %0d want %0d", k, got[k], k); end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 5; c++) begin
      idle(1'b0);
      for (int p = 0; p < NP; p++) set_port(p, 8'($urandom_range(1, 255)), {$urandom, $urandom});
      tick();
    end
    idle(1'b1);
    for (int c = 0; c < 10; c++) tick();
    n_cmp++;
    if (level !== 5'd6 || drop_count !== 16'd4) begin
      n_err++; $display("FAIL areset_pre: got l=%0d drop=%0d want 6 4", level, drop_count);
    end
    #2; reset = 1'b1; mq.delete(); mdrop = 0;
    #1;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL areset_immediate: got %h want 0", obs); end
    set_port(0, 8'd9, 64'h99);
    @(posedge clock); #1;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL areset_edge: got %h want 0", obs); end
    idle(1'b1); reset = 1'b0; #1;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL areset_release: got %h want 0", obs); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      in_valid  = 4'($urandom);
      io_coreid = 8'($urandom);
      out_ready = (i < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      for (int p = 0; p < NP; p++) begin
        in_address[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        in_data[p*DW +: DW]    = {$urandom, $urandom};
      end
      tick();
      n_cmp++;
      if (obs !== exp_state()) begin n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_state()); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b0);
    test_reset();
    test_single();
    test_multi_order();
    test_x0_filter();
    test_overflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/difftest_int_wb_queue.md
DIFFTEST_INT_WB_QUEUE -- requirements
Module: difftest_int_wb_queue

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of parallel integer writeback ports.
REQ-002 SHALL have parameter ADDR_W, default 8: register address width.
REQ-003 SHALL have parameter DATA_W, default 64: writeback data width.
REQ-004 SHALL have parameter DEPTH, default 16: queue entries; power of two, minimum NUM_PORTS.
REQ-005 SHALL have parameter FILTER_X0, default 1: when 1, a write to address 0 is discarded silently.
REQ-006 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 SHALL have port enable, input, 1 bit: global capture enable.
REQ-009 SHALL have port in_valid, input, NUM_PORTS bits: per-port writeback valid.
REQ-010 SHALL have port in_address, input, NUM_PORTS*ADDR_W bits: port p occupies slice [p*ADDR_W +: ADDR_W].
REQ-011 SHALL have port in_data, input, NUM_PORTS*DATA_W bits: port p occupies slice [p*DATA_W +: DATA_W].
REQ-012 SHALL have port io_coreid, input, 8 bits: core id, sampled and stored with each entry.
REQ-013 SHALL have port out_valid, output, 1 bit: queue head is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: sink accepts the head.
REQ-015 SHALL have ports out_address (ADDR_W), out_data (DATA_W) and out_coreid (8), all outputs: head entry fields.
REQ-016 SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-017 SHALL have port drop_count, output, 16 bits: saturating count of entries lost to overflow.

Function
REQ-018 SHALL qualify a port p as eligible when enable=1, in_valid[p]=1, and NOT (FILTER_X0=1 and in_address[p]=0).
REQ-019 SHALL compute free space as DEPTH-level at the start of the cycle; a pop in the same cycle does not add space that cycle.
REQ-020 SHALL enqueue eligible ports in ascending port index, contiguously at the write pointer, up to the free space, all in one cycle.
REQ-021 SHALL discard eligible ports beyond the free space and add their number to drop_count, saturating at 16'hFFFF.
REQ-022 SHALL treat filtered x0 writes and writes with enable=0 as neither enqueued nor dropped.
REQ-023 SHALL present the head first-word-fall-through: out_valid=1 exactly when level!=0, with head fields valid in the same cycle.
REQ-024 SHALL drive out_address, out_data and out_coreid to 0 when out_valid=0.
REQ-025 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1; out_ready with an empty queue has no effect.
REQ-026 SHALL update level each cycle as level + enqueued - popped; simultaneous push and pop are both honoured.
REQ-027 SHALL wrap read and write pointers modulo DEPTH.
REQ-028 SHALL have a minimum latency of 1 cycle from capture to out_valid; an entry pushed at edge N appears at the head after edge N when the queue was empty.
REQ-029 SHALL keep pop behaviour independent of enable; draining continues with enable=0.

Reset
REQ-030 SHALL, while reset=1, asynchronously force level=0, both pointers=0, drop_count=0 and out_valid=0, with out_address, out_data and out_coreid at 0.
REQ-031 SHALL discard all queued entries on reset asserted mid-operation; no pop or push SHALL occur on edges while reset=1.
REQ-032 SHALL leave queue storage contents unreset; they are unobservable because of REQ-024.

Verification
REQ-033 SHALL cover single port: port 0 writes addr 5, data 0x1234, coreid 0, out_ready=1 -> next cycle head = (5, 0x1234, 0), level=1; the following cycle level=0.
REQ-034 SHALL cover multi-port order: ports 0-3 write addrs 1,2,3,4 in one cycle, out_ready=0 -> level=4; then draining yields addrs 1,2,3,4 in that order.
REQ-035 SHALL cover x0 filter: port 1 writes addr 0 and port 2 writes addr 7 -> only addr 7 is enqueued, drop_count unchanged.
REQ-036 SHALL cover overflow: level=14, out_ready=1, all 4 ports eligible -> ports 0 and 1 are enqueued, drop_count += 2, level=15 after the edge.
REQ-037 SHALL cover wrap: push and pop 40 entries with incrementing data through DEPTH=16 -> data exits in order with no loss and drop_count=0.
REQ-038 SHALL cover async reset: reset pulsed mid-cycle with level=6 -> out_valid, level and drop_count go to 0 immediately, without waiting for a clock edge.
